// File: rtl/bus_relay_fifo.sv
// rtl/bus_relay_fifo.sv - buffered valid/ready relay FIFO with optional output bit reversal
// Define BUS_RELAY_LEVEL_EN to add the level and overflow_sticky output ports.
module bus_relay_fifo #(
    parameter int               WIDTH   = 5,
    parameter int               DEPTH   = 4,
    parameter int               REVERSE = 0,
    parameter logic [WIDTH-1:0] INIT    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data
`ifdef BUS_RELAY_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow_sticky
`endif
);

    localparam int              AW     = $clog2(DEPTH);
    localparam int              CW     = AW + 1;
    localparam logic [CW-1:0]   C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_word;

    // Both handshakes are masked by rst so nothing is presented or accepted during reset.
    assign in_ready  = (r_count != C_FULL) && !rst;
    assign out_valid = (r_count != '0) && !rst;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    // Words are stored in producer bit order; reversal happens only on the way out.
    always_comb begin
        w_word = w_head;
        if (REVERSE != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_word[i] = w_head[WIDTH-1-i];
            end
        end
    end

    assign out_data = out_valid ? w_word : INIT;

`ifdef BUS_RELAY_LEVEL_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && (r_count == C_FULL)) begin
            r_overflow <= 1'b1;
        end
    end

    assign level           = r_count;
    assign overflow_sticky = r_overflow;
`endif

endmodule

// File: tb/tb_bus_relay_fifo.sv
// tb/tb_bus_relay_fifo.sv - scoreboard bench for bus_relay_fifo, straight and reversed instances
module tb_bus_relay_fifo;

    localparam int           W      = 5;
    localparam int           D      = 4;
    localparam logic [W-1:0] INIT_A = 5'h00;
    localparam logic [W-1:0] INIT_B = 5'h0A;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;

    logic         in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [W-1:0] out_data_a, out_data_b;
`ifdef BUS_RELAY_LEVEL_EN
    logic [2:0]   level_a, level_b;
    logic         ovf_a, ovf_b;
`endif

    bus_relay_fifo #(.WIDTH(W), .DEPTH(D), .REVERSE(0), .INIT(INIT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
`ifdef BUS_RELAY_LEVEL_EN
        , .level(level_a), .overflow_sticky(ovf_a)
`endif
    );

    bus_relay_fifo #(.WIDTH(W), .DEPTH(D), .REVERSE(1), .INIT(INIT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
`ifdef BUS_RELAY_LEVEL_EN
        , .level(level_b), .overflow_sticky(ovf_b)
`endif
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    int           m_count = 0;
    bit           m_ovf = 1'b0;

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[W-1-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model across the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic o);
        bit push, pop;
        rst = r; in_valid = v; in_data = d; out_ready = o;
        @(posedge clk);
        if (r) begin
            m_count = 0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            push = v && (m_count != D);
            pop  = o && (m_count != 0);
            if (v && (m_count == D)) m_ovf = 1'b1;
            if (push) exp_q.push_back(d);
            m_count = m_count + int'(push) - int'(pop);
        end
        #2;
    endtask

    logic         ev;
    logic [W-1:0] head;

    always @(negedge clk) begin
        ev = !rst && (m_count != 0);
        check("in_ready_a", in_ready_a, !rst && (m_count != D));
        check("in_ready_b", in_ready_b, !rst && (m_count != D));
        check("out_valid_a", out_valid_a, ev);
        check("out_valid_b", out_valid_b, ev);
        if (ev && exp_q.size() > 0) begin
            head = exp_q[0];
            check("out_data_a", out_data_a, head);
            check("out_data_b_rev", out_data_b, rev(head));
            if (out_ready) void'(exp_q.pop_front());
        end else begin
            check("out_data_a_init", out_data_a, INIT_A);
            check("out_data_b_init", out_data_b, INIT_B);
        end
`ifdef BUS_RELAY_LEVEL_EN
        check("level_a", level_a, m_count);
        check("level_b", level_b, m_count);
        check("overflow_a", ovf_a, m_ovf);
        check("overflow_b", ovf_b, m_ovf);
`endif
    end

    logic [W-1:0] pend;
    bit           pend_v;
    bit           v, o, r, acc;

    initial begin
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        // single word
        step(0, 1, 5'h13, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        // fill, pop while full (push refused), refill across the wrap
        for (int i = 1; i <= 4; i++) step(0, 1, W'(i), 0);
        step(0, 1, 5'h05, 1);
        step(0, 1, 5'h05, 1);
        step(0, 1, 5'h06, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        // reversal pattern
        step(0, 1, 5'b10110, 0);
        step(0, 0, '0, 1);
        // push and pop together with one word held
        step(0, 1, 5'h07, 0);
        step(0, 1, 5'h08, 1);
        step(0, 0, '0, 1);
        // reset mid-stream after an overflow attempt
        for (int i = 0; i < 4; i++) step(0, 1, W'(5'h10 + i), 0);
        step(0, 1, 5'h19, 0);
        step(0, 0, '0, 0);
        step(1, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        // randomized traffic with producer holding data until accepted
        pend_v = 1'b0;
        pend   = '0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) == 0);
            if (pend_v) v = 1'b1;
            else begin
                v = ($urandom_range(0, 9) < 6);
                pend = W'($urandom);
            end
            o = ($urandom_range(0, 9) < 5);
            acc = v && !r && (m_count != D);
            step(r, v, pend, o);
            pend_v = v && !acc && !r;
        end
        for (int i = 0; i < D + 2; i++) step(0, 0, '0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
